// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first, repeat_cnt times,
// with a programmable idle gap between repetitions. All outputs are registered.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   reps_q, reps_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               x_out_q, x_out_d;
  logic               x_valid_q, x_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      reps_q        <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      idx_q         <= '0;
      x_out_q       <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      reps_q        <= reps_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      idx_q         <= idx_d;
      x_out_q       <= x_out_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d   = pattern;
          reps_d  = repeat_cnt;
          gap_d   = gap;
          idx_d   = MSB_IDX;
          state_d = (repeat_cnt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (reps_q > CNT_W'(1)) begin
          reps_d = reps_q - CNT_W'(1);
          idx_d  = MSB_IDX;
          // A zero gap restarts from the MSB on the very next cycle.
          if (gap_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q - GAP_W'(1);
          end
        end else begin
          reps_d  = reps_q - CNT_W'(1);
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they line up with state_q.
  always_comb begin
    x_valid_d     = (state_d == S_SHIFT);
    x_out_d       = x_valid_d & pat_d[idx_d];
    frame_start_d = x_valid_d && (idx_d == MSB_IDX);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-cycle expected output vectors written by hand,
// outputs packed as {x_out, x_valid, frame_start, busy, done}.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       abort;
  logic       x_out, x_valid, frame_start, busy, done;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] I  = 5'b00000;
  localparam logic [4:0] F0 = 5'b01110;
  localparam logic [4:0] F1 = 5'b11110;
  localparam logic [4:0] B0 = 5'b01010;
  localparam logic [4:0] B1 = 5'b11010;
  localparam logic [4:0] G  = 5'b00010;
  localparam logic [4:0] D  = 5'b00011;

  typedef struct {
    logic       st;
    logic       ab;
    logic [3:0] pat;
    logic [7:0] rep;
    logic [3:0] gp;
    logic [4:0] exp;
  } vec_t;

  vec_t vq[$];

  seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pattern     (pattern),
    .repeat_cnt  (repeat_cnt),
    .gap         (gap),
    .abort       (abort),
    .x_out       (x_out),
    .x_valid     (x_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Start request with given transfer parameters.
  task automatic add_start(input logic [3:0] pat, input logic [7:0] rep, input logic [3:0] gp,
                           input logic [4:0] exp);
    vq.push_back('{1'b1, 1'b0, pat, rep, gp, exp});
  endtask

  // Non-start cycle; inputs carry junk so a failure to hold captured values shows up.
  task automatic add_idle(input logic [4:0] exp);
    vq.push_back('{1'b0, 1'b0, 4'b1011, 8'd7, 4'd9, exp});
  endtask

  // Each entry: drive inputs after a falling edge, check outputs at the following falling edge.
  task automatic play(input string tag);
    int n = 0;
    foreach (vq[i]) begin
      start      = vq[i].st;
      abort      = vq[i].ab;
      pattern    = vq[i].pat;
      repeat_cnt = vq[i].rep;
      gap        = vq[i].gp;
      @(negedge clk);
      n++;
      check($sformatf("%s_c%0d", tag, n), {x_out, x_valid, frame_start, busy, done}, vq[i].exp);
    end
    start = 1'b0;
    abort = 1'b0;
    vq.delete();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_cnt = '0; gap = '0;
    #3;
    check("reset", {x_out, x_valid, frame_start, busy, done}, I);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset", {x_out, x_valid, frame_start, busy, done}, I);

    // 0101 once, no gap
    add_start(4'b0101, 8'd1, 4'd0, F0);
    add_idle(B1); add_idle(B0); add_idle(B1); add_idle(D); add_idle(I);
    play("single");

    // 0101 twice, back-to-back
    add_start(4'b0101, 8'd2, 4'd0, F0);
    add_idle(B1); add_idle(B0); add_idle(B1);
    add_idle(F0); add_idle(B1); add_idle(B0); add_idle(B1);
    add_idle(D); add_idle(I);
    play("b2b");

    // 1100 three times, gap 2
    add_start(4'b1100, 8'd3, 4'd2, F1);
    add_idle(B1); add_idle(B0); add_idle(B0); add_idle(G); add_idle(G);
    add_idle(F1); add_idle(B1); add_idle(B0); add_idle(B0); add_idle(G); add_idle(G);
    add_idle(F1); add_idle(B1); add_idle(B0); add_idle(B0);
    add_idle(D); add_idle(I);
    play("gap2");

    // 1000 twice, gap 1 (shortest gap)
    add_start(4'b1000, 8'd2, 4'd1, F1);
    add_idle(B0); add_idle(B0); add_idle(B0); add_idle(G);
    add_idle(F1); add_idle(B0); add_idle(B0); add_idle(B0);
    add_idle(D); add_idle(I);
    play("gap1");

    // repeat_cnt = 0: done only
    add_start(4'b1111, 8'd0, 4'd3, D);
    add_idle(I); add_idle(I);
    play("rep0");

    // start ignored mid-transfer, abort during third bit of second repetition
    add_start(4'b0101, 8'd2, 4'd0, F0);
    add_idle(B1);
    vq.push_back('{1'b1, 1'b0, 4'b1111, 8'd9, 4'd0, B0});
    add_idle(B1); add_idle(F0); add_idle(B1); add_idle(B0);
    vq.push_back('{1'b0, 1'b1, 4'b1011, 8'd7, 4'd9, I});
    add_idle(I); add_idle(I);
    play("abort");

    // abort and start together in IDLE: abort wins; abort alone in IDLE is harmless
    vq.push_back('{1'b1, 1'b1, 4'b1111, 8'd1, 4'd0, I});
    vq.push_back('{1'b0, 1'b1, 4'b1111, 8'd1, 4'd0, I});
    add_start(4'b1010, 8'd1, 4'd0, F1);
    add_idle(B0); add_idle(B1); add_idle(B0); add_idle(D); add_idle(I);
    play("idle_abort");

    // Async reset mid-SHIFT, then a clean restart from MSB
    add_start(4'b1111, 8'd3, 4'd0, F1);
    add_idle(B1);
    play("pre_rst");
    #2 rst = 1'b0;
    #1 check("async_rst", {x_out, x_valid, frame_start, busy, done}, I);
    @(negedge clk);
    check("rst_hold", {x_out, x_valid, frame_start, busy, done}, I);
    rst = 1'b1;
    add_idle(I);
    add_start(4'b0101, 8'd1, 4'd0, F0);
    add_idle(B1); add_idle(B0); add_idle(B1); add_idle(D); add_idle(I);
    play("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
